// File: rtl/mips_avalon_arbiter_if.sv
// Avalon-MM signal bundle shared by the fetch, data and memory sides
// of the two-port CPU bus arbiter.
interface mips_avalon_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

    modport fetch (
        input  address, read,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// Shares one Avalon-MM master between the CPU fetch (read-only) port
// and the data port; round-robin or data-first on ties.
module mips_avalon_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_avalon_arbiter_if.fetch  ibus,
    mips_avalon_arbiter_if.slave  dbus,
    mips_avalon_arbiter_if.master mem,
    output logic [1:0]            grant
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   req_i;
    logic   req_d;
    logic   tie_to_d;

    assign req_i = ibus.read;
    assign req_d = dbus.read | dbus.write;

    // Round-robin favours the port that did not finish last; fixed mode favours D.
    assign tie_to_d = ROUND_ROBIN ? ~last_grant : 1'b1;

    // Read data is broadcast; each port samples only on its own completion.
    assign ibus.readdata = mem.readdata;
    assign dbus.readdata = mem.readdata;

    // Ownership FSM: grant on request, hand over or idle on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i && req_d)
                        state <= tie_to_d ? BUS_D : BUS_I;
                    else if (req_d)
                        state <= BUS_D;
                    else if (req_i)
                        state <= BUS_I;
                end
                BUS_I: begin
                    if (!req_i) begin
                        state <= IDLE;
                    end else if (!mem.waitrequest) begin
                        last_grant <= 1'b0;
                        state      <= req_d ? BUS_D : IDLE;
                    end
                end
                BUS_D: begin
                    if (!req_d) begin
                        state <= IDLE;
                    end else if (!mem.waitrequest) begin
                        last_grant <= 1'b1;
                        state      <= req_i ? BUS_I : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux: the owner drives memory directly; everyone else is stalled.
    always_comb begin
        mem.address      = {ADDR_W{1'b0}};
        mem.read         = 1'b0;
        mem.write        = 1'b0;
        mem.writedata    = {DATA_W{1'b0}};
        mem.byteenable   = {BE_W{1'b0}};
        ibus.waitrequest = 1'b1;
        dbus.waitrequest = 1'b1;
        grant            = 2'b00;
        unique case (state)
            BUS_I: begin
                mem.address      = ibus.address;
                mem.read         = ibus.read;
                mem.byteenable   = {BE_W{1'b1}};
                ibus.waitrequest = mem.waitrequest;
                grant            = 2'b01;
            end
            BUS_D: begin
                mem.address      = dbus.address;
                mem.read         = dbus.read;
                mem.write        = dbus.write;
                mem.writedata    = dbus.writedata;
                mem.byteenable   = dbus.byteenable;
                dbus.waitrequest = mem.waitrequest;
                grant            = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Vector-table bench for mips_avalon_arbiter: one round-robin and one
// fixed-priority instance share the same stimulus.
module tb_mips_avalon_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [3:0]  BF  = 4'hF;
    localparam logic [3:0]  B0  = 4'h0;
    localparam logic [31:0] A_F = 32'hBFC00000;
    localparam logic [31:0] INS = 32'h24020005;

    localparam logic [1:0] O_IDLE = 2'd0;
    localparam logic [1:0] O_I    = 2'd1;
    localparam logic [1:0] O_D    = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_address;
    logic        i_read;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [1:0]  grant_rr;
    logic [1:0]  grant_fp;

    always #5 clk = ~clk;

    mips_avalon_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib_rr ();
    mips_avalon_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) db_rr ();
    mips_avalon_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mb_rr ();
    mips_avalon_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib_fp ();
    mips_avalon_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) db_fp ();
    mips_avalon_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mb_fp ();

    assign ib_rr.address    = i_address;
    assign ib_rr.read       = i_read;
    assign ib_rr.write      = 1'b0;
    assign ib_rr.writedata  = '0;
    assign ib_rr.byteenable = '0;
    assign db_rr.address    = d_address;
    assign db_rr.read       = d_read;
    assign db_rr.write      = d_write;
    assign db_rr.writedata  = d_writedata;
    assign db_rr.byteenable = d_byteenable;
    assign mb_rr.waitrequest = waitrequest;
    assign mb_rr.readdata    = readdata;

    assign ib_fp.address    = i_address;
    assign ib_fp.read       = i_read;
    assign ib_fp.write      = 1'b0;
    assign ib_fp.writedata  = '0;
    assign ib_fp.byteenable = '0;
    assign db_fp.address    = d_address;
    assign db_fp.read       = d_read;
    assign db_fp.write      = d_write;
    assign db_fp.writedata  = d_writedata;
    assign db_fp.byteenable = d_byteenable;
    assign mb_fp.waitrequest = waitrequest;
    assign mb_fp.readdata    = readdata;

    mips_avalon_arbiter #(
        .ROUND_ROBIN(1'b1), .ADDR_W(AW), .DATA_W(DW)
    ) dut_rr (
        .clk(clk), .rst(rst), .ibus(ib_rr), .dbus(db_rr),
        .mem(mb_rr), .grant(grant_rr)
    );

    mips_avalon_arbiter #(
        .ROUND_ROBIN(1'b0), .ADDR_W(AW), .DATA_W(DW)
    ) dut_fp (
        .clk(clk), .rst(rst), .ibus(ib_fp), .dbus(db_fp),
        .mem(mb_fp), .grant(grant_fp)
    );

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        wr;
        logic [31:0] rd;
        logic        fp;
        logic [1:0]  own;
    } vec_t;

    typedef logic [137:0] bund_t;

    vec_t  vecs[$];
    bund_t sb[$];
    int    checks = 0;
    int    fails  = 0;

    task automatic add(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da,
        input logic [31:0] dwd, input logic [3:0] dbe,
        input logic wr, input logic [31:0] rd,
        input logic fp, input logic [1:0] own
    );
        vec_t v;
        v.rst = r;  v.ir = ir; v.ia = ia;
        v.dr = dr;  v.dw = dw; v.da = da;
        v.dwd = dwd; v.dbe = dbe;
        v.wr = wr;  v.rd = rd;
        v.fp = fp;  v.own = own;
        vecs.push_back(v);
    endtask

    // Expected bus view given which port the vector says owns the bus.
    function automatic bund_t expect_of(input vec_t v);
        logic [1:0]  g;
        logic        rdv, wrv, iwv, dwv;
        logic [31:0] addr, wd;
        logic [3:0]  be;
        g = 2'b00; rdv = 1'b0; wrv = 1'b0; addr = '0; wd = '0;
        be = '0; iwv = 1'b1; dwv = 1'b1;
        if (v.own == O_I) begin
            g = 2'b01; rdv = v.ir; addr = v.ia; be = 4'hF; iwv = v.wr;
        end else if (v.own == O_D) begin
            g = 2'b10; rdv = v.dr; wrv = v.dw; addr = v.da;
            wd = v.dwd; be = v.dbe; dwv = v.wr;
        end
        return {g, rdv, wrv, addr, wd, be, iwv, dwv, v.rd, v.rd};
    endfunction

    function automatic bund_t actual(input logic fp);
        if (fp)
            return {grant_fp, mb_fp.read, mb_fp.write, mb_fp.address,
                    mb_fp.writedata, mb_fp.byteenable,
                    ib_fp.waitrequest, db_fp.waitrequest,
                    ib_fp.readdata, db_fp.readdata};
        return {grant_rr, mb_rr.read, mb_rr.write, mb_rr.address,
                mb_rr.writedata, mb_rr.byteenable,
                ib_rr.waitrequest, db_rr.waitrequest,
                ib_rr.readdata, db_rr.readdata};
    endfunction

    task automatic drive(input vec_t v);
        rst          = v.rst;
        i_read       = v.ir;
        i_address    = v.ia;
        d_read       = v.dr;
        d_write      = v.dw;
        d_address    = v.da;
        d_writedata  = v.dwd;
        d_byteenable = v.dbe;
        waitrequest  = v.wr;
        readdata     = v.rd;
    endtask

    initial begin
        bund_t exp_b, got_b;
        vec_t  v;
        rst = 1'b0; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0;
        d_writedata = '0; d_byteenable = '0;
        waitrequest = 1'b0; readdata = '0;

        // reset holds everything idle even with both ports requesting
        add(L, H, A_F, H, L, Z, Z, B0, L, Z, L, O_IDLE);
        // single fetch, then re-request must pass through IDLE
        add(H, H, A_F, L, L, Z, Z, B0, L, INS, L, O_IDLE);
        add(H, H, A_F, L, L, Z, Z, B0, L, INS, L, O_I);
        add(H, H, A_F, L, L, Z, Z, B0, L, INS, L, O_IDLE);
        add(H, H, A_F, L, L, Z, Z, B0, L, INS, L, O_I);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        // contention after reset: D first, I with no gap
        add(L, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        add(H, H, 32'h100, L, H, 32'h1000, 32'hDEADBEEF, BF, L, Z, L, O_IDLE);
        add(H, H, 32'h100, L, H, 32'h1000, 32'hDEADBEEF, BF, L, Z, L, O_D);
        add(H, H, 32'h100, L, L, 32'h1000, 32'hDEADBEEF, BF, L, 32'h11111111, L, O_I);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        // round-robin rotation: D last, so next tie goes to I
        add(H, L, Z, H, L, 32'h2000, Z, BF, L, Z, L, O_IDLE);
        add(H, L, Z, H, L, 32'h2000, Z, BF, L, 32'h22222222, L, O_D);
        add(H, H, 32'h104, H, L, 32'h2000, Z, BF, L, Z, L, O_IDLE);
        add(H, H, 32'h104, H, L, 32'h2000, Z, BF, L, 32'h33, L, O_I);
        add(H, L, Z, H, L, 32'h2000, Z, BF, L, 32'h44, L, O_D);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        // waitrequest stretch of three cycles on a D read
        add(H, L, Z, H, L, 32'h3000, Z, BF, H, Z, L, O_IDLE);
        add(H, L, Z, H, L, 32'h3000, Z, BF, H, Z, L, O_D);
        add(H, L, Z, H, L, 32'h3000, Z, BF, H, Z, L, O_D);
        add(H, L, Z, H, L, 32'h3000, Z, BF, H, Z, L, O_D);
        add(H, L, Z, H, L, 32'h3000, Z, BF, L, 32'h55, L, O_D);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        // abort keeps last_grant=D, so the following tie goes to I
        add(H, L, Z, H, L, 32'h4000, Z, BF, H, Z, L, O_IDLE);
        add(H, L, Z, H, L, 32'h4000, Z, BF, H, Z, L, O_D);
        add(H, L, Z, L, L, 32'h4000, Z, BF, H, Z, L, O_D);
        add(H, H, 32'h108, H, L, 32'h4004, Z, BF, L, Z, L, O_IDLE);
        add(H, H, 32'h108, H, L, 32'h4004, Z, BF, L, 32'h66, L, O_I);
        add(H, L, Z, H, L, 32'h4004, Z, BF, L, 32'h77, L, O_D);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        // reset in the middle of a stalled D write clears last_grant
        add(H, L, Z, L, H, 32'h5000, 32'hCAFEF00D, 4'h3, H, Z, L, O_IDLE);
        add(H, L, Z, L, H, 32'h5000, 32'hCAFEF00D, 4'h3, H, Z, L, O_D);
        add(L, L, Z, L, H, 32'h5000, 32'hCAFEF00D, 4'h3, H, Z, L, O_IDLE);
        add(H, H, 32'h10C, H, L, 32'h5004, Z, BF, L, Z, L, O_IDLE);
        add(H, H, 32'h10C, H, L, 32'h5004, Z, BF, L, 32'h88, L, O_D);
        add(H, H, 32'h10C, L, L, 32'h5004, Z, BF, L, 32'h99, L, O_I);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, L, O_IDLE);
        // fixed priority: IDLE ties go to D even after D finished last
        add(L, L, Z, L, L, Z, Z, B0, L, Z, H, O_IDLE);
        add(H, H, 32'h110, H, L, 32'h6000, Z, BF, L, Z, H, O_IDLE);
        add(H, L, Z, H, L, 32'h6000, Z, BF, L, 32'hA1, H, O_D);
        add(H, H, 32'h110, H, L, 32'h6004, Z, BF, L, Z, H, O_IDLE);
        add(H, L, Z, H, L, 32'h6004, Z, BF, L, 32'hA2, H, O_D);
        add(H, H, 32'h110, H, L, 32'h6008, Z, BF, L, Z, H, O_IDLE);
        add(H, H, 32'h110, H, L, 32'h6008, Z, BF, L, 32'hA3, H, O_D);
        add(H, H, 32'h110, H, L, 32'h600C, Z, BF, L, 32'hA4, H, O_I);
        add(H, L, Z, H, L, 32'h600C, Z, BF, L, 32'hA5, H, O_D);
        add(H, L, Z, L, L, Z, Z, B0, L, Z, H, O_IDLE);

        @(negedge clk);
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v);
            sb.push_back(expect_of(v));
            #4;
            got_b = actual(v.fp);
            exp_b = sb.pop_front();
            checks++;
            if (got_b !== exp_b) begin
                fails++;
                $display("FAIL vec%0d fp=%0d: got %h required %h",
                         i, v.fp, got_b, exp_b);
            end
            @(negedge clk);
        end

        // asynchronous reset must drop the strobes mid-cycle
        rst = 1'b0; d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
        @(negedge clk);
        rst = 1'b1; d_read = 1'b1; d_address = 32'h7000;
        waitrequest = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (!(mb_rr.read === 1'b1 && grant_rr === 2'b10)) begin
            fails++;
            $display("FAIL pre_rst: read=%b grant=%b required read=1 grant=10",
                     mb_rr.read, grant_rr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (!(mb_rr.read === 1'b0 && grant_rr === 2'b00 &&
              mb_rr.address === 32'h0 && db_rr.waitrequest === 1'b1)) begin
            fails++;
            $display("FAIL async_rst: read=%b grant=%b addr=%h dwait=%b required 0 00 0 1",
                     mb_rr.read, grant_rr, mb_rr.address, db_rr.waitrequest);
        end
        @(negedge clk);
        rst = 1'b1; d_read = 1'b0; waitrequest = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
